// File: rtl/tdm_demux_1x4_3bit_pkg.sv
// Shared encodings for the 1-to-4 TDM demultiplexer: channel/slot codes and default word width.
package tdm_demux_1x4_3bit_pkg;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_X = 2'd0;
  localparam slot_t SLOT_Y = 2'd1;
  localparam slot_t SLOT_Z = 2'd2;
  localparam slot_t SLOT_W = 2'd3;

  localparam int unsigned DEFAULT_WIDTH = 3;

endpackage

// File: rtl/tdm_demux_1x4_3bit_decoder_2x4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder_2x4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux_1x4_3bit.sv
// Time-division demultiplexer: routes each valid word to one of four registered channels,
// selected manually by {s1,s0} or by a free-running slot counter in auto mode.
module tdm_demux_1x4_3bit
  import tdm_demux_1x4_3bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             auto,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] w,
  output logic             x_vld,
  output logic             y_vld,
  output logic             z_vld,
  output logic             w_vld,
  output logic [1:0]       slot,
  output logic             frame_done
);

  slot_t            sel;
  slot_t            slot_d, slot_q;
  logic [3:0]       we;
  logic [3:0]       vld_q;
  logic             frame_done_d, frame_done_q;
  logic [WIDTH-1:0] ch_q [4];

  always_comb begin
    sel = {s1, s0};
    if (auto) begin
      sel = frame_sync ? SLOT_X : slot_q;
    end
  end

  decoder_2x4 u_decoder (
    .sel    (sel),
    .en     (d_valid),
    .onehot (we)
  );

  // An accepted word always advances past its own slot, so a synced word leaves slot at 1.
  always_comb begin
    slot_d = slot_q;
    if (auto) begin
      if (d_valid) begin
        slot_d = sel + 2'd1;
      end else if (frame_sync) begin
        slot_d = SLOT_X;
      end
    end
  end

  assign frame_done_d = auto & d_valid & (sel == SLOT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= SLOT_X;
      vld_q        <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      slot_q       <= slot_d;
      vld_q        <= we;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          ch_q[i] <= d;
        end else if (HOLD == 0) begin
          ch_q[i] <= '0;
        end
      end
    end
  end

  assign x          = ch_q[SLOT_X];
  assign y          = ch_q[SLOT_Y];
  assign z          = ch_q[SLOT_Z];
  assign w          = ch_q[SLOT_W];
  assign x_vld      = vld_q[SLOT_X];
  assign y_vld      = vld_q[SLOT_Y];
  assign z_vld      = vld_q[SLOT_Z];
  assign w_vld      = vld_q[SLOT_W];
  assign slot       = slot_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tdm_demux_1x4_3bit.sv
// Directed bench: a HOLD=1 and a HOLD=0 instance share one stimulus stream.
module tb_tdm_demux_1x4_3bit;

  logic       clk = 1'b0;
  logic       rst, d_valid, s0, s1, auto, frame_sync;
  logic [2:0] d;

  logic [2:0] hx, hy, hz, hw, nx, ny, nz, nw;
  logic       hxv, hyv, hzv, hwv, nxv, nyv, nzv, nwv;
  logic [1:0] hslot, nslot;
  logic       hfd, nfd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_demux_1x4_3bit #(.WIDTH(3), .HOLD(1)) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .s0(s0), .s1(s1), .auto(auto),
    .frame_sync(frame_sync), .x(hx), .y(hy), .z(hz), .w(hw), .x_vld(hxv), .y_vld(hyv),
    .z_vld(hzv), .w_vld(hwv), .slot(hslot), .frame_done(hfd)
  );

  tdm_demux_1x4_3bit #(.WIDTH(3), .HOLD(0)) dut_nh (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .s0(s0), .s1(s1), .auto(auto),
    .frame_sync(frame_sync), .x(nx), .y(ny), .z(nz), .w(nw), .x_vld(nxv), .y_vld(nyv),
    .z_vld(nzv), .w_vld(nwv), .slot(nslot), .frame_done(nfd)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] dd, input logic dv, input logic au,
                      input logic fs, input logic [1:0] s);
    rst = r; d = dd; d_valid = dv; auto = au; frame_sync = fs; {s1, s0} = s;
    @(posedge clk);
    #1;
  endtask

  // h*: expected HOLD=1 outputs, n*: expected HOLD=0 channel values; vld is {x,y,z,w}.
  task automatic expect_out(input string tag,
                            input logic [2:0] ex, input logic [2:0] ey,
                            input logic [2:0] ez, input logic [2:0] ew,
                            input logic [3:0] vld, input logic [1:0] sl, input logic fd,
                            input logic [2:0] ex0, input logic [2:0] ey0,
                            input logic [2:0] ez0, input logic [2:0] ew0);
    chk({tag, ".h.chan"}, {4'h0, hx, hy, hz, hw}, {4'h0, ex, ey, ez, ew});
    chk({tag, ".h.vld"}, {12'h0, hxv, hyv, hzv, hwv}, {12'h0, vld});
    chk({tag, ".h.slot"}, {14'h0, hslot}, {14'h0, sl});
    chk({tag, ".h.frame_done"}, {15'h0, hfd}, {15'h0, fd});
    chk({tag, ".n.chan"}, {4'h0, nx, ny, nz, nw}, {4'h0, ex0, ey0, ez0, ew0});
    chk({tag, ".n.vld"}, {12'h0, nxv, nyv, nzv, nwv}, {12'h0, vld});
    chk({tag, ".n.slot"}, {14'h0, nslot}, {14'h0, sl});
    chk({tag, ".n.frame_done"}, {15'h0, nfd}, {15'h0, fd});
  endtask

  initial begin
    // Reset with junk inputs held active.
    step(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 2'b11);
    step(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 2'b11);
    expect_out("reset", 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    step(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 2'b10);
    expect_out("manual_z", 0, 0, 5, 0, 4'b0010, 0, 0, 0, 0, 5, 0);

    // Full auto frame.
    step(1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("auto_x", 1, 0, 5, 0, 4'b1000, 1, 0, 1, 0, 0, 0);
    step(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("auto_y", 1, 2, 5, 0, 4'b0100, 2, 0, 0, 2, 0, 0);
    step(1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("auto_z", 1, 2, 3, 0, 4'b0010, 3, 0, 0, 0, 3, 0);
    step(1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("auto_w", 1, 2, 3, 4, 4'b0001, 0, 1, 0, 0, 0, 4);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00);
    expect_out("auto_idle", 1, 2, 3, 4, 4'b0000, 0, 0, 0, 0, 0, 0);

    // frame_sync colliding with a word at slot 2.
    step(1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("sync_pre_x", 1, 2, 3, 4, 4'b1000, 1, 0, 1, 0, 0, 0);
    step(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("sync_pre_y", 1, 2, 3, 4, 4'b0100, 2, 0, 0, 2, 0, 0);
    step(1'b0, 3'd6, 1'b1, 1'b1, 1'b1, 2'b00);
    expect_out("sync_collide", 6, 2, 3, 4, 4'b1000, 1, 0, 6, 0, 0, 0);

    // Manual/auto interleave; slot preserved across the manual write.
    step(1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 2'b00);
    expect_out("mix_auto_x", 7, 2, 3, 4, 4'b1000, 1, 0, 7, 0, 0, 0);
    step(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 2'b11);
    expect_out("mix_manual_w", 7, 2, 3, 2, 4'b0001, 1, 0, 0, 0, 0, 2);
    step(1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 2'b11);
    expect_out("mix_auto_y", 7, 3, 3, 2, 4'b0100, 2, 0, 0, 3, 0, 0);

    // HOLD behaviour; frame_sync is ignored in manual mode.
    step(1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 2'b01);
    expect_out("hold_write_y", 7, 4, 3, 2, 4'b0100, 2, 0, 0, 4, 0, 0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01);
    expect_out("hold_idle", 7, 4, 3, 2, 4'b0000, 2, 0, 0, 0, 0, 0);

    // Reset mid-frame.
    step(1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 2'b00);
    expect_out("mid_x", 1, 4, 3, 2, 4'b1000, 1, 0, 1, 0, 0, 0);
    step(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("mid_y", 1, 2, 3, 2, 4'b0100, 2, 0, 0, 2, 0, 0);
    step(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("mid_reset", 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 2'b00);
    expect_out("post_reset_x", 5, 0, 0, 0, 4'b1000, 1, 0, 5, 0, 0, 0);

    // Idle frame_sync in auto mode clears the slot.
    step(1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 2'b00);
    expect_out("sync_idle", 5, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x4_3bit.md
Name: tdm_demux_1x4_3bit

Overview:
- Time-division demultiplexer: accepts one 3-bit word stream and distributes each valid word into one of four registered output channels (x, y, z, w).
- Channel is chosen either by the manual select lines {s1,s0} or by an internal slot counter that steps through the channels in auto mode.
- Serves as the receive-side counterpart of the 4-to-1, 3-bit selection path; a word muxed out on select value k lands back on channel k.

Parameters:
- WIDTH, 3, data word width in bits for d and for each channel output.
- HOLD, 1, 1 = channel outputs keep their last written value; 0 = a channel output returns to 0 on any cycle in which its strobe is low.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d  input  WIDTH  input data word.
- d_valid  input  1  d is valid this cycle.
- s0  input  1  manual select, bit 0.
- s1  input  1  manual select, bit 1.
- auto  input  1  1 = route by the internal slot counter; 0 = route by {s1,s0}.
- frame_sync  input  1  forces the slot counter to 0 (auto mode only).
- x, y, z, w  output  WIDTH each  channel registers 0..3.
- x_vld, y_vld, z_vld, w_vld  output  1 each  one-cycle strobe: the channel was written this cycle.
- slot  output  2  current slot counter value.
- frame_done  output  1  one-cycle pulse when channel w is written in auto mode.

Behaviour:
- Reset: while rst=1 at a clock edge, x/y/z/w=0, all _vld=0, slot=0, frame_done=0. Reset dominates every other input. A partially filled frame is discarded.
- Latency: one cycle. The word presented with d_valid at edge N appears on its channel, with the matching _vld=1, after edge N.
- Target channel sel:
  - auto=0: sel={s1,s0}. 00→x, 01→y, 10→z, 11→w.
  - auto=1 and frame_sync=1: sel=0.
  - auto=1 and frame_sync=0: sel=slot.
- Write rule: d_valid=1 loads d into the sel channel and asserts that channel's _vld for exactly one cycle. Exactly one _vld is high per accepted word.
- d_valid=0: no _vld asserted. Channel values follow HOLD.
- Slot counter (2-bit, wraps 3→0), auto=1:
  - d_valid=1, frame_sync=0: slot <= slot+1.
  - d_valid=1, frame_sync=1: word goes to x, slot <= 1.
  - d_valid=0, frame_sync=1: slot <= 0.
  - d_valid=0, frame_sync=0: slot holds.
- Slot counter, auto=0: slot holds its value. frame_sync is ignored.
- Mode switching is legal on any cycle and takes effect the same cycle. slot is preserved across switches.
- frame_done: registered, asserted in the same cycle as w_vld when that write was routed by the slot counter (auto=1, sel=3). Never asserted in manual mode.
- Back-to-back valid words are accepted every cycle, with no stalls or backpressure.

Decomposition:
- Shared constants file: channel/slot encodings SLOT_X=2'd0, SLOT_Y=2'd1, SLOT_Z=2'd2, SLOT_W=2'd3, and default WIDTH.
- One sub-module, decoder_2x4: 2-bit select plus enable in, 4-bit one-hot write-enable out. Purely combinational.
- The top level holds the slot counter, mode/select logic, channel registers and strobes.

Test Plan:
- Reset: drive junk inputs, rst=1 for 2 cycles → all outputs 0, slot=0. Release, d=3'b101, d_valid=1, auto=0, {s1,s0}=10 → next cycle z=5, z_vld=1, others' vld=0.
- Auto frame: auto=1, d_valid=1 for 4 cycles with d=1,2,3,4 → x=1, y=2, z=3, w=4 in successive cycles; frame_done=1 only with w_vld; slot returns to 0.
- frame_sync collision: auto=1, slot=2, d=6, d_valid=1, frame_sync=1 → x=6, x_vld=1, slot=1, z unchanged.
- Manual/auto interleave: auto=1 writes x=7 (slot→1); auto=0, sel=11 writes d=2 → w=2, frame_done=0, slot stays 1; auto=1, d=3 → y=3.
- HOLD=0 build: write y=4, then d_valid=0 for one cycle → y=0 that cycle. HOLD=1 build, same stimulus → y stays 4.
- Reset mid-frame: auto=1, after writes to x and y assert rst one cycle → all channels 0, slot=0. Next valid word d=5 → x=5.
